// File: rtl/gcm_pkg.sv
// Shared GCM definitions: block type, GHASH reduction constant and the
// GHASH/tag FSM state encoding.
package gcm_pkg;

  localparam int unsigned GCM_BLK_W = 128;
  localparam int unsigned GCM_CNT_W = 32;

  typedef logic [GCM_BLK_W-1:0] gcm_block_t;

  // Reduction constant in GCM bit order (0xE1 followed by 120 zero bits).
  localparam gcm_block_t GCM_R = {8'hE1, 120'd0};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    MUL     = 3'd2,
    LEN     = 3'd3,
    MUL_LEN = 3'd4,
    DONE    = 3'd5
  } ghash_state_t;

endpackage : gcm_pkg

// File: rtl/gf128_digit_mul.sv
// One DIGIT-bit step of the GF(2^128) shift-and-add multiplier.
// Ports:
//   x_bits   - next DIGIT multiplier bits, MSB processed first
//   z, v     - current accumulator and shifted multiplicand
//   z_next_c - accumulator after the step (combinational)
//   v_next_c - multiplicand after the step (combinational)
module gf128_digit_mul
  import gcm_pkg::*;
#(
  parameter int unsigned DIGIT = 8
) (
  input  logic [DIGIT-1:0] x_bits,
  input  gcm_block_t       z,
  input  gcm_block_t       v,
  output gcm_block_t       z_next_c,
  output gcm_block_t       v_next_c
);

  gcm_block_t z_t;
  gcm_block_t v_t;

  // Bit 127 is GCM bit 0, so a GCM right shift is a plain >> here.
  always_comb begin
    z_t = z;
    v_t = v;
    for (int i = int'(DIGIT) - 1; i >= 0; i--) begin
      if (x_bits[i]) z_t = z_t ^ v_t;
      v_t = v_t[0] ? ((v_t >> 1) ^ GCM_R) : (v_t >> 1);
    end
    z_next_c = z_t;
    v_next_c = v_t;
  end

endmodule : gf128_digit_mul

// File: rtl/gcm_ghash_tag.sv
// GHASH accumulator and GCM tag generator. Ciphertext (and optionally AAD)
// blocks are folded into Y one at a time; on finish the length block is
// hashed and the tag Y ^ E(K,Y0) is strobed out.
// Optional feature macro: GCM_GHASH_AAD_EN adds i_is_aad so blocks can be
// counted toward len(A); without it len(A) is always zero.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   i_new               - start message: latch i_h / i_ek_y0, clear Y and counts
//   i_h, i_ek_y0        - hash subkey H and E(K,Y0)
//   i_valid, i_block    - input block, taken in WAIT
//   i_is_aad            - (GCM_GHASH_AAD_EN only) block is AAD
//   i_finish            - end of message, taken in WAIT when i_valid is low
//   o_ready             - high only in WAIT
//   o_tag, o_tag_valid  - tag and its one-cycle strobe
module gcm_ghash_tag
  import gcm_pkg::*;
#(
  parameter int unsigned DIGIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_new,
  input  gcm_block_t i_h,
  input  gcm_block_t i_ek_y0,
  input  logic       i_valid,
  input  gcm_block_t i_block,
`ifdef GCM_GHASH_AAD_EN
  input  logic       i_is_aad,
`endif
  input  logic       i_finish,
  output logic       o_ready,
  output gcm_block_t o_tag,
  output logic       o_tag_valid
);

  localparam int unsigned STEPS = GCM_BLK_W / DIGIT;
  localparam int unsigned STEP_W = $clog2(STEPS);

  ghash_state_t          state_q, state_d;
  gcm_block_t            y_q, x_q, z_q, v_q, h_q, ek_q;
  logic [STEP_W-1:0]     step_q;
  logic [GCM_CNT_W-1:0]  cnt_a_q, cnt_c_q;
  logic                  ready_d, tag_valid_d, last_step;
  gcm_block_t            z_next_c, v_next_c, len_blk;

  assign last_step = (step_q == STEP_W'(STEPS - 1));

  // Lengths in bits: block count * 128.
  assign len_blk = {25'd0, cnt_a_q, 7'd0, 25'd0, cnt_c_q, 7'd0};

  gf128_digit_mul #(.DIGIT(DIGIT)) u_digit (
    .x_bits   (x_q[GCM_BLK_W-1 -: DIGIT]),
    .z        (z_q),
    .v        (v_q),
    .z_next_c (z_next_c),
    .v_next_c (v_next_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and registered-output decode; i_new wins over everything.
  always_comb begin
    state_d     = state_q;
    tag_valid_d = 1'b0;
    if (i_new) begin
      state_d = WAIT;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        WAIT: begin
          if (i_valid)       state_d = MUL;
          else if (i_finish) state_d = LEN;
        end
        MUL:     if (last_step) state_d = WAIT;
        LEN:     state_d = MUL_LEN;
        MUL_LEN: if (last_step) state_d = DONE;
        DONE: begin
          state_d     = IDLE;
          tag_valid_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    ready_d = (state_d == WAIT);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ready     <= 1'b0;
      o_tag_valid <= 1'b0;
      o_tag       <= '0;
      y_q         <= '0;
      x_q         <= '0;
      z_q         <= '0;
      v_q         <= '0;
      h_q         <= '0;
      ek_q        <= '0;
      step_q      <= '0;
      cnt_a_q     <= '0;
      cnt_c_q     <= '0;
    end else begin
      o_ready     <= ready_d;
      o_tag_valid <= tag_valid_d;
      if (tag_valid_d) o_tag <= z_q ^ ek_q;

      if (i_new) begin
        h_q     <= i_h;
        ek_q    <= i_ek_y0;
        y_q     <= '0;
        cnt_a_q <= '0;
        cnt_c_q <= '0;
      end else begin
        case (state_q)
          WAIT: begin
            if (i_valid) begin
              x_q    <= y_q ^ i_block;
              z_q    <= '0;
              v_q    <= h_q;
              step_q <= '0;
`ifdef GCM_GHASH_AAD_EN
              if (i_is_aad) begin
                if (cnt_a_q != '1) cnt_a_q <= cnt_a_q + GCM_CNT_W'(1);
              end else begin
                if (cnt_c_q != '1) cnt_c_q <= cnt_c_q + GCM_CNT_W'(1);
              end
`else
              if (cnt_c_q != '1) cnt_c_q <= cnt_c_q + GCM_CNT_W'(1);
`endif
            end
          end
          LEN: begin
            x_q    <= y_q ^ len_blk;
            z_q    <= '0;
            v_q    <= h_q;
            step_q <= '0;
          end
          MUL, MUL_LEN: begin
            z_q    <= z_next_c;
            v_q    <= v_next_c;
            x_q    <= x_q << DIGIT;
            step_q <= step_q + STEP_W'(1);
            if (last_step) y_q <= z_next_c;
          end
          default: ;
        endcase
      end
    end
  end

endmodule : gcm_ghash_tag

// File: tb/tb_gcm_ghash_tag.sv
// Self-checking bench for gcm_ghash_tag (DIGIT=8). Reference tags come from
// a polynomial-form GF(2^128) multiply over the queued message blocks.
// Define GCM_GHASH_AAD_EN to also exercise the AAD length path.
module tb_gcm_ghash_tag;

  localparam logic [127:0] KH = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] KE = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] KC = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] KT = 128'hab6e47d42cec13bdf53a67b21257bddf;
`ifdef GCM_GHASH_AAD_EN
  localparam bit AAD_ON = 1'b1;
`else
  localparam bit AAD_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_new = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_finish = 1'b0;
  logic [127:0] i_h = '0;
  logic [127:0] i_ek_y0 = '0;
  logic [127:0] i_block = '0;
`ifdef GCM_GHASH_AAD_EN
  logic         i_is_aad = 1'b0;
`endif
  logic         o_ready;
  logic         o_tag_valid;
  logic [127:0] o_tag;

  int n_tests = 0;
  int n_fail = 0;

  logic [127:0] m_h, m_ek;
  logic [127:0] m_blk[$];
  bit           m_aad[$];

  gcm_ghash_tag #(.DIGIT(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_new       (i_new),
    .i_h         (i_h),
    .i_ek_y0     (i_ek_y0),
    .i_valid     (i_valid),
    .i_block     (i_block),
`ifdef GCM_GHASH_AAD_EN
    .i_is_aad    (i_is_aad),
`endif
    .i_finish    (i_finish),
    .o_ready     (o_ready),
    .o_tag       (o_tag),
    .o_tag_valid (o_tag_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // GCM bit order -> polynomial coefficient order (bit i = coeff of x^i).
  function automatic logic [127:0] brev(input logic [127:0] a);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = a[127-i];
    return r;
  endfunction

  // Carry-less product reduced modulo x^128 + x^7 + x^2 + x + 1.
  function automatic logic [127:0] gmul(input logic [127:0] a, input logic [127:0] b);
    logic [254:0] p;
    logic [127:0] ra, rb;
    ra = brev(a);
    rb = brev(b);
    p  = '0;
    for (int i = 0; i < 128; i++)
      if (rb[i]) p = p ^ ({127'd0, ra} << i);
    for (int i = 254; i >= 128; i--) begin
      if (p[i]) begin
        p[i]     = 1'b0;
        p[i-128] = ~p[i-128];
        p[i-127] = ~p[i-127];
        p[i-126] = ~p[i-126];
        p[i-121] = ~p[i-121];
      end
    end
    return brev(p[127:0]);
  endfunction

  function automatic logic [127:0] ref_tag();
    logic [127:0] y;
    logic [63:0]  la, lc;
    y  = '0;
    la = '0;
    lc = '0;
    foreach (m_blk[k]) begin
      y = gmul(y ^ m_blk[k], m_h);
      if (m_aad[k]) la = la + 64'd128;
      else          lc = lc + 64'd128;
    end
    y = gmul(y ^ {la, lc}, m_h);
    return y ^ m_ek;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg(input logic [127:0] h, input logic [127:0] ek);
    i_h     = h;
    i_ek_y0 = ek;
    i_new   = 1'b1;
    tick();
    i_new   = 1'b0;
    m_h     = h;
    m_ek    = ek;
    m_blk.delete();
    m_aad.delete();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!o_ready && n < 100) begin
      tick();
      n++;
    end
    if (!o_ready) chk("ready_timeout", 128'(o_ready), 128'd1);
  endtask

  task automatic send_block(input logic [127:0] blk, input bit aad);
    int lat;
    wait_ready();
    i_valid = 1'b1;
    i_block = blk;
`ifdef GCM_GHASH_AAD_EN
    i_is_aad = aad;
`endif
    tick();
    i_valid = 1'b0;
    m_blk.push_back(blk);
    m_aad.push_back(aad & AAD_ON);
    lat = 0;
    while (!o_ready && lat < 100) begin
      tick();
      lat++;
    end
    chk("blk_latency", 128'(lat), 128'd16);
  endtask

  task automatic finish_msg(input string name);
    int lat;
    wait_ready();
    i_finish = 1'b1;
    tick();
    i_finish = 1'b0;
    lat = 0;
    while (!o_tag_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk({name, "_latency"}, 128'(lat), 128'd18);
    chk({name, "_tag"}, o_tag, ref_tag());
    tick();
    chk({name, "_strobe_once"}, 128'(o_tag_valid), 128'd0);
  endtask

  initial begin
    int seen, bad, accepts, nb;

    // Reset state and no self-start after release.
    tick();
    chk("rst_ready", 128'(o_ready), 128'd0);
    chk("rst_tag_valid", 128'(o_tag_valid), 128'd0);
    chk("rst_tag", o_tag, 128'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_after_release", 128'(o_ready), 128'd0);

    // Known-answer vectors.
    start_msg(KH, KE);
    finish_msg("empty");
    chk("empty_kat", o_tag, KE);

    start_msg(KH, KE);
    send_block(KC, 1'b0);
    finish_msg("one_blk");
    chk("one_blk_kat", o_tag, KT);

`ifdef GCM_GHASH_AAD_EN
    start_msg(KH, KE);
    send_block(128'd0, 1'b1);
    send_block(KC, 1'b0);
    finish_msg("aad");
`endif

    // Random messages.
    for (int m = 0; m < 6; m++) begin
      start_msg(rand128(), rand128());
      nb = int'($urandom_range(0, 4));
      for (int b = 0; b < nb; b++) send_block(rand128(), 1'($urandom_range(0, 1)));
      finish_msg("rand");
    end

    // Back-pressure: i_valid held high, ready must pulse once every 17 cycles.
    start_msg(rand128(), rand128());
    bad     = 0;
    accepts = 0;
    i_block = rand128();
    i_valid = 1'b1;
    for (int k = 0; k <= 50; k++) begin
      if (o_ready !== ((k % 17) == 0)) bad++;
      if (o_ready) begin
        m_blk.push_back(i_block);
        m_aad.push_back(1'b0);
        accepts++;
      end
      tick();
      if (m_blk.size() == accepts && accepts > 0 && k % 17 == 0) i_block = rand128();
    end
    i_valid = 1'b0;
    chk("bp_ready_pattern", 128'(bad), 128'd0);
    chk("bp_accepts", 128'(accepts), 128'd3);
    finish_msg("bp");

    // Reset in the middle of a multiply.
    start_msg(rand128(), rand128());
    wait_ready();
    i_valid = 1'b1;
    i_block = rand128();
    tick();
    i_valid = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 128'(o_ready), 128'd0);
    chk("midrst_tag_valid", 128'(o_tag_valid), 128'd0);
    chk("midrst_tag", o_tag, 128'd0);
    #1;
    rst_n    = 1'b1;
    i_valid  = 1'b1;
    i_finish = 1'b1;
    seen     = 0;
    repeat (20) begin
      tick();
      if (o_ready || o_tag_valid) seen = 1;
    end
    i_valid  = 1'b0;
    i_finish = 1'b0;
    chk("midrst_stays_idle", 128'(seen), 128'd0);
    start_msg(rand128(), rand128());
    send_block(rand128(), 1'b0);
    send_block(rand128(), 1'b0);
    finish_msg("post_rst");

    // i_new while the length block is being multiplied.
    start_msg(rand128(), rand128());
    send_block(rand128(), 1'b0);
    wait_ready();
    i_finish = 1'b1;
    tick();
    i_finish = 1'b0;
    repeat (6) tick();
    start_msg(rand128(), rand128());
    seen = 0;
    repeat (25) begin
      if (o_tag_valid) seen = 1;
      tick();
    end
    chk("abort_no_strobe", 128'(seen), 128'd0);
    send_block(rand128(), 1'b0);
    send_block(rand128(), 1'b0);
    finish_msg("abort_next");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_gcm_ghash_tag

// File: doc/gcm_ghash_tag.md
GCM_GHASH_TAG -- requirements
Module: gcm_ghash_tag

Interface
REQ-001 SHALL have parameter DIGIT, default 8, meaning GF(2^128) multiplier bits processed per cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port i_new, input, 1 bit: start a new message; latches i_h and i_ek_y0, clears the accumulator Y and the block counters.
REQ-005 SHALL have port i_h, input, 128 bits: hash subkey H = E(K, 0^128).
REQ-006 SHALL have port i_ek_y0, input, 128 bits: E(K, Y0), XORed into the final tag.
REQ-007 SHALL have ports i_valid (input, 1 bit) and i_block (input, 128 bits): a ciphertext block from the aes_api o_cipher_text / o_cp_ready path.
REQ-008 SHALL have port i_finish, input, 1 bit: end of message; triggers the length-block pass.
REQ-009 SHALL have port o_ready, output, 1 bit: block and finish acceptance allowed.
REQ-010 SHALL have ports o_tag (output, 128 bits) and o_tag_valid (output, 1 bit): the authentication tag, and a 1-cycle strobe marking it.

Function
REQ-011 SHALL number bits in GCM convention: bit 127 of any 128-bit port is GCM bit 0, the leftmost bit.
REQ-012 SHALL implement the FSM states IDLE, WAIT, MUL, LEN, MUL_LEN and DONE.
REQ-013 SHALL move from any state to WAIT on i_new; i_new has priority over all other inputs in the same cycle.
REQ-014 SHALL assert o_ready only in WAIT.
REQ-015 SHALL accept a block in WAIT when i_valid=1: X <= Y ^ i_block, then enter MUL.
REQ-016 SHALL accept finish in WAIT when i_finish=1 and i_valid=0; finish goes to LEN.
REQ-017 SHALL give i_valid priority over i_finish when both are high; the finish is then ignored.
REQ-018 SHALL make MUL and MUL_LEN last exactly 128/DIGIT cycles (16 when DIGIT=8).
- Each cycle processes DIGIT bits of X, MSB first.
- Per bit: Z ^= V when the bit is 1; then V <= V[0] ? (V>>1) ^ R : V>>1, with R = 0xE1 followed by 120 zero bits.
- At the end: Y <= Z, and MUL returns to WAIT.
REQ-019 SHALL make LEN a 1-cycle state: X <= Y ^ {len(A)[63:0], len(C)[63:0]}, then enter MUL_LEN.
- len(C) = block count × 128.
REQ-020 SHALL, at the end of MUL_LEN, enter DONE with o_tag <= Z ^ ek_y0_reg and o_tag_valid=1 for exactly one cycle, then go to IDLE.
REQ-021 SHALL hold o_tag in IDLE until the next i_new.
REQ-022 SHALL meet these latencies when DIGIT=8:
- o_ready reasserts 16 edges after block acceptance, so blocks are accepted once per 17 cycles at most.
- o_tag_valid rises 18 edges after finish acceptance.
REQ-023 SHALL ignore i_valid and i_finish outside WAIT; no buffering, and the upstream holds its block until o_ready.
REQ-024 SHALL saturate the 32-bit block counters at all-ones; they never wrap.
REQ-025 SHALL treat an empty message (i_new then i_finish) as a valid message that produces o_tag = ek_y0.

Reset
REQ-026 SHALL, on rst_n=0 at any time including mid-multiply, asynchronously set:
- state=IDLE, o_ready=0, o_tag_valid=0, o_tag=0;
- Y, X, Z, V, H, ek_y0_reg and the counters all to 0.
REQ-027 SHALL leave the state in IDLE when reset is released; a new i_new is required to start a message.

Configuration
REQ-028 SHALL, when GCM_GHASH_AAD_EN is defined:
- add port i_is_aad (input, 1 bit), sampled with i_valid;
- count an accepted block with i_is_aad=1 toward len(A), and otherwise toward len(C);
- ignore i_is_aad as a type flag when i_valid is low.
REQ-029 SHALL, when GCM_GHASH_AAD_EN is undefined:
- have no i_is_aad port;
- drive len(A) to 0;
- count every accepted block toward len(C).

Structure
REQ-030 SHALL place the following in shared package gcm_pkg:
- typedef gcm_block_t (logic [127:0]);
- constant GCM_R (128'hE1 << 120);
- enum ghash_state_t.
REQ-031 SHALL put the digit step in one sub-module, gf128_digit_mul: combinational, one DIGIT-bit step of Z/V, instanced once and shared by MUL and MUL_LEN.

Verification
REQ-032 SHALL cover empty message: H=66e94bd4ef8a2c3b884cfa59ca342b2e, ek_y0=58e2fccefa7e3061367f1d57a4e7455a, i_new then i_finish -> o_tag=58e2fccefa7e3061367f1d57a4e7455a, strobed once.
REQ-033 SHALL cover a single block: same H and ek_y0, block 0388dace60b6a392f328c2b971b2fe78, then finish -> o_tag=ab6e47d42cec13bdf53a67b21257bddf.
REQ-034 SHALL cover back-pressure: i_valid held high continuously -> o_ready pattern is 1 cycle high, 16 cycles low; block count equals the number of acceptances.
REQ-035 SHALL cover reset mid-MUL: rst_n=0 during cycle 8 of 16 -> all outputs 0 immediately, state IDLE; a subsequent message gives the correct tag.
REQ-036 SHALL cover i_new during MUL_LEN: no o_tag_valid strobe, and the next message tag equals its standalone reference tag.
REQ-037 SHALL cover, with GCM_GHASH_AAD_EN defined, one AAD block of 0 plus REQ-033's ciphertext -> length block = 0x80 || 0x80, and the tag matches the software model.
